// File: rtl/ldpc_pkg.sv
// Shared definitions for the systematic (15,7) LDPC code: parity-check rows,
// column weights, decoder state encoding and the generator equations.
package ldpc_pkg;

    localparam int N = 15;
    localparam int K = 7;
    localparam int M = 8;

    // Row r holds the word bits that participate in check s_r (bit 0 = w0).
    localparam logic [M-1:0][N-1:0] H_ROWS = {
        15'h4045,   // s7: w0 w2 w6 w14
        15'h2067,   // s6: w0 w1 w2 w5 w6 w13
        15'h1076,   // s5: w1 w2 w4 w5 w6 w12
        15'h083B,   // s4: w0 w1 w3 w4 w5 w11
        15'h0458,   // s3: w3 w4 w6 w10
        15'h022C,   // s2: w2 w3 w5 w9
        15'h0116,   // s1: w1 w2 w4 w8
        15'h008B    // s0: w0 w1 w3 w7
    };

    localparam logic [N-1:0][2:0] COL_WEIGHT = {
        3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
        3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd4
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } dec_state_t;

    typedef struct packed {
        dec_state_t     state;
        logic [M-1:0]   syndrome;
    } dec_dbg_t;

    // Parity bit 7+r is the XOR of the info bits covered by check r.
    function automatic logic [N-1:0] ldpc_encode(input logic [K-1:0] info);
        logic [N-1:0] w;
        w = '0;
        w[K-1:0] = info;
        for (int r = 0; r < M; r++) begin
            w[K+r] = ^(H_ROWS[r][K-1:0] & info);
        end
        return w;
    endfunction

endpackage

// File: rtl/ldpc_bitflip_decoder_if.sv
// Input/output handshake bundle of the bit-flipping decoder.
// valid/ready: a transfer happens on a rising edge where both are high; the
// source holds its payload stable while valid is high and ready is low.
interface ldpc_bitflip_decoder_if #(
    parameter int ITER_W = 4
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [ldpc_pkg::N-1:0]   in_word;
    logic                     out_valid;
    logic                     out_ready;
    logic [ldpc_pkg::K-1:0]   dout;
    logic                     dec_ok;
    logic [ITER_W-1:0]        dec_iter;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, dout, dec_ok, dec_iter
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, dout, dec_ok, dec_iter
    );

endinterface

// File: rtl/ldpc_flip_select.sv
// Combinational flip selection: syndrome of a word and the bit with the
// highest score 2*unsatisfied_checks - column_weight (ties to lowest index).
module ldpc_flip_select
    import ldpc_pkg::*;
(
    input  logic [N-1:0]       word,
    output logic [M-1:0]       syndrome,
    output logic [3:0]         cand_idx,
    output logic signed [4:0]  max_score,
    output logic               syn_zero
);

    logic signed [4:0] score [N];

    function automatic logic signed [4:0] bit_score(input logic [M-1:0] syn, input int j);
        logic [3:0]        cnt;
        logic signed [5:0] s6;
        cnt = '0;
        for (int r = 0; r < M; r++) begin
            cnt = cnt + {3'b000, syn[r] & H_ROWS[r][j]};
        end
        s6 = $signed({1'b0, cnt, 1'b0}) - $signed({3'b000, COL_WEIGHT[j]});
        return s6[4:0];
    endfunction

    always_comb begin
        for (int r = 0; r < M; r++) begin
            syndrome[r] = ^(word & H_ROWS[r]);
        end
    end

    assign syn_zero = ~|syndrome;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            score[j] = bit_score(syndrome, j);
        end
    end

    // Strict greater-than keeps the earliest index on equal scores.
    always_comb begin
        cand_idx  = '0;
        max_score = score[0];
        for (int j = 1; j < N; j++) begin
            if (score[j] > max_score) begin
                max_score = score[j];
                cand_idx  = 4'(j);
            end
        end
    end

endmodule

// File: rtl/ldpc_bitflip_decoder.sv
// Iterative hard-decision bit-flipping decoder for the (15,7) LDPC code:
// one word in flight, one flip per clock until the syndrome clears or the limit hits.
module ldpc_bitflip_decoder
    import ldpc_pkg::*;
#(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ldpc_bitflip_decoder_if.slave     bus,
    output dec_dbg_t                  dbg
);

    dec_state_t          state_q, state_d;
    logic [N-1:0]        word_q, word_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                ok_q, ok_d;

    logic [M-1:0]        syndrome;
    logic [3:0]          cand_idx;
    logic signed [4:0]   max_score;
    logic                syn_zero;
    logic [N-1:0]        flip_mask;

    ldpc_flip_select u_flip_select (
        .word      (word_q),
        .syndrome  (syndrome),
        .cand_idx  (cand_idx),
        .max_score (max_score),
        .syn_zero  (syn_zero)
    );

    assign flip_mask = {{(N-1){1'b0}}, 1'b1} << cand_idx;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        iter_d  = iter_q;
        ok_d    = ok_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_word;
                    iter_d  = '0;
                    ok_d    = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (syn_zero) begin
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else if ((iter_q == ITER_W'(MAX_ITER)) || (max_score <= 5'sd0)) begin
                    // No bit is more suspect than trusted, or the budget is spent.
                    ok_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    word_d = word_q ^ flip_mask;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            iter_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            iter_q  <= iter_d;
            ok_q    <= ok_d;
        end
    end

    // Result fields come straight from registers that do not move in DONE.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.dout      = word_q[K-1:0];
    assign bus.dec_ok    = ok_q;
    assign bus.dec_iter  = iter_q;

    assign dbg.state    = state_q;
    assign dbg.syndrome = syndrome;

endmodule
